// File: rtl/ahb_sram_slave_pkg.sv
// Shared types and helpers for the AHB-Lite SRAM slave.
//  htrans_e      : AHB transfer type encoding
//  hsize_e       : AHB transfer size encoding
//  hresp_e       : AHB response encoding
//  slave_state_e : slave response FSM states
//  size_to_be()  : byte-enable mask from transfer size and low address bits
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slave_state_e;

    localparam int MAX_LANES = 8;

    // Mask is sized for the widest bus; narrower buses use the low lanes.
    // Alignment has already been checked, so the shift never wraps lanes.
    function automatic logic [MAX_LANES-1:0] size_to_be(input logic [2:0] size,
                                                        input logic [2:0] addr_lo);
        logic [MAX_LANES-1:0] base;
        case (size)
            3'd0:    base = 8'h01;
            3'd1:    base = 8'h03;
            3'd2:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << addr_lo;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite slave-side bus bundle.
//  master modport : drives address/control/write data, receives HREADYOUT/HRESP/HRDATA
//  slave  modport : the reverse
// HREADY is the bus-level ready fed back from the interconnect.
interface ahb_sram_slave_if
    import ahb_sram_slave_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
);
    logic          HSEL;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [1:0]    HTRANS;
    logic [DW-1:0] HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [DW-1:0] HRDATA;

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_sram_slave_bank.sv
// DEPTH x DW memory bank.
//  clk/srst      : clock, synchronous active-high reset (clears read register only)
//  we/be/waddr/wdata : single write port with per-byte enables
//  re/raddr/rdata    : registered read port; a same-cycle write to the same word
//                      is merged lane by lane into the returned data
module ahb_sram_slave_bank #(
    parameter int DW    = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     srst,
    input  logic                     we,
    input  logic [DW/8-1:0]          be,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);
    localparam int NB = DW / 8;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_reg;
    logic [DW-1:0] fwd_word;

    // A write landing on the reset edge belongs to an aborted transfer.
    always_ff @(posedge clk) begin
        if (!srst && we) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign fwd_word[gi*8 +: 8] = (we && be[gi] && (waddr == raddr)) ?
                                         wdata[gi*8 +: 8] : mem[raddr][gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            rdata_reg <= '0;
        end else if (re) begin
            rdata_reg <= fwd_word;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave with byte lanes, programmable wait states and
// two-cycle ERROR response.
//  HCLK   : clock
//  HRESET : synchronous active-high reset
//  bus    : AHB-Lite slave port (ahb_sram_slave_if.slave)
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic           HCLK,
    input  logic           HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int         NB       = DW / 8;
    localparam int         BOFF     = $clog2(NB);
    localparam int         WIDX     = $clog2(DEPTH);
    localparam int         MEM_BITS = WIDX + BOFF;
    localparam logic [3:0] WS_LOAD  = 4'(WAIT_STATES);

    slave_state_e  state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          dp_valid_reg, dp_valid_next;
    logic          dp_write_reg;
    logic [2:0]    dp_size_reg;
    logic [AW-1:0] dp_addr_reg;

    logic          active, addr_err, size_err, align_err, accept_ok, accept_err;
    logic [2:0]    align_mask;

    // New address phases are only taken while our own HREADYOUT is high.
    assign active     = bus.HSEL & bus.HTRANS[1] & bus.HREADY &
                        ((state_reg == ST_IDLE) | (state_reg == ST_ERR2));
    assign addr_err   = |bus.HADDR[AW-1:MEM_BITS];
    assign size_err   = bus.HSIZE > 3'(BOFF);
    assign align_mask = (3'd1 << bus.HSIZE) - 3'd1;
    assign align_err  = |(bus.HADDR[2:0] & align_mask);
    assign accept_err = active & (addr_err | size_err | align_err);
    assign accept_ok  = active & ~(addr_err | size_err | align_err);

    // An OKAY data phase lives through the wait states and ends in the
    // first IDLE-state cycle after it.
    assign dp_valid_next = accept_ok | (dp_valid_reg & (state_reg == ST_WAIT));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE, ST_ERR2: begin
                state_next = ST_IDLE;
                if (accept_err) begin
                    state_next = ST_ERR1;
                end else if (accept_ok && (WAIT_STATES > 0)) begin
                    state_next = ST_WAIT;
                    cnt_next   = WS_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_size_reg  <= '0;
            dp_addr_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            dp_valid_reg <= dp_valid_next;
            if (accept_ok) begin
                dp_write_reg <= bus.HWRITE;
                dp_size_reg  <= bus.HSIZE;
                dp_addr_reg  <= bus.HADDR;
            end
        end
    end

    assign bus.HREADYOUT = (state_reg != ST_WAIT) && (state_reg != ST_ERR1);
    assign bus.HRESP     = ((state_reg == ST_ERR1) || (state_reg == ST_ERR2)) ?
                           HRESP_ERROR : HRESP_OKAY;

    logic [7:0]      be_full;
    logic [NB-1:0]   be;
    logic            we, re;
    logic [WIDX-1:0] waddr, raddr;

    assign be_full = size_to_be(dp_size_reg, 3'(dp_addr_reg[BOFF-1:0]));
    assign be      = be_full[NB-1:0];
    assign we      = dp_valid_reg & dp_write_reg & (state_reg == ST_IDLE);
    assign waddr   = dp_addr_reg[MEM_BITS-1:BOFF];

    // Read data is loaded on the edge that opens the final data cycle:
    // the accept edge itself when there are no wait states, otherwise the
    // edge leaving the last wait cycle.
    generate
        if (WAIT_STATES == 0) begin : g_zero_wait
            assign re    = accept_ok & ~bus.HWRITE;
            assign raddr = bus.HADDR[MEM_BITS-1:BOFF];
        end else begin : g_wait
            assign re    = (state_reg == ST_WAIT) & (cnt_reg == 4'd1) &
                           dp_valid_reg & ~dp_write_reg;
            assign raddr = dp_addr_reg[MEM_BITS-1:BOFF];
        end
    endgenerate

    // HBURST is not needed for decode; upper mask/address bits are don't-care.
    logic unused_bits;
    assign unused_bits = ^{bus.HBURST, be_full, dp_addr_reg};

    ahb_sram_slave_bank #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk   (HCLK),
        .srst  (HRESET),
        .we    (we),
        .be    (be),
        .waddr (waddr),
        .wdata (bus.HWDATA),
        .re    (re),
        .raddr (raddr),
        .rdata (bus.HRDATA)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one zero-wait instance driven from a
// per-cycle vector table, one three-wait instance driven by hand sequences.
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst;
    logic hold0;

    ahb_sram_slave_if #(.DW(32), .AW(32)) i0 ();
    ahb_sram_slave_if #(.DW(32), .AW(32)) i3 ();

    assign i0.HREADY = i0.HREADYOUT & ~hold0;
    assign i3.HREADY = i3.HREADYOUT;

    ahb_sram_slave #(.DW(32), .AW(32), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESET(srst), .bus(i0));
    ahb_sram_slave #(.DW(32), .AW(32), .DEPTH(64), .WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESET(srst), .bus(i3));

    localparam logic [1:0] ID = 2'd0, BU = 2'd1, NS = 2'd2, SQ = 2'd3;

    typedef struct {
        logic        sel;
        logic [1:0]  tr;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rdy;
        logic        resp;
        logic        chk;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                                logic [31:0] a, logic [31:0] wd, logic rdy, logic resp,
                                logic chk, logic [31:0] rd);
        vec_t v;
        v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd;
        v.rdy = rdy; v.resp = resp; v.chk = chk; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive0(input logic sel, input logic [1:0] tr, input logic wr,
                          input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        i0.HSEL = sel; i0.HTRANS = tr; i0.HWRITE = wr; i0.HSIZE = sz;
        i0.HADDR = a; i0.HWDATA = wd; i0.HBURST = 3'd0;
    endtask

    task automatic step0(input logic sel, input logic [1:0] tr, input logic wr,
                         input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        drive0(sel, tr, wr, sz, a, wd);
        @(negedge clk);
    endtask

    // One transfer on the wait-state instance; counts HREADYOUT-low data cycles.
    task automatic xfer3(input logic wr, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output int lows, output logic resp,
                         output logic [31:0] rd);
        @(posedge clk); #1;
        i3.HSEL = 1'b1; i3.HTRANS = NS; i3.HWRITE = wr; i3.HSIZE = sz;
        i3.HADDR = a; i3.HWDATA = 32'h0;
        @(negedge clk);
        lows = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            i3.HSEL = 1'b0; i3.HTRANS = ID; i3.HWDATA = wd;
            @(negedge clk);
            if (i3.HREADYOUT) break;
            lows++;
        end
        resp = i3.HRESP;
        rd   = i3.HRDATA;
        $display("ws3 xfer wr=%0d size=%0d addr=%h lows=%0d resp=%0d rdata=%h",
                 wr, sz, a, lows, resp, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          lows;
        logic        resp;
        logic [31:0] rd;

        // Zero-wait vector table: each row is one clock cycle. Address-phase
        // fields belong to this cycle's transfer, wd is the data for the
        // previous transfer, expectations are the outputs seen this cycle.
        vt.push_back(mk(1, NS, 1, 2, 32'h10,  32'h0,        1, 0, 1, 32'h0));
        vt.push_back(mk(1, NS, 0, 2, 32'h10,  32'hDEADBEEF, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        1, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(1, NS, 1, 2, 32'h20,  32'h0,        1, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(1, NS, 1, 0, 32'h21,  32'h0,        1, 0, 0, 32'h0));
        vt.push_back(mk(1, NS, 1, 1, 32'h22,  32'h0000AB00, 1, 0, 0, 32'h0));
        vt.push_back(mk(1, NS, 0, 2, 32'h20,  32'h12340000, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        1, 0, 1, 32'h1234AB00));
        vt.push_back(mk(1, NS, 1, 2, 32'h30,  32'h0,        1, 0, 1, 32'h1234AB00));
        vt.push_back(mk(1, NS, 1, 0, 32'h30,  32'h11223344, 1, 0, 0, 32'h0));
        vt.push_back(mk(1, NS, 0, 2, 32'h30,  32'hFFFFFF55, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        1, 0, 1, 32'h11223355));
        vt.push_back(mk(1, NS, 0, 2, 32'h100, 32'h0,        1, 0, 1, 32'h11223355));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        0, 1, 1, 32'h11223355));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        1, 1, 1, 32'h11223355));
        vt.push_back(mk(1, NS, 1, 2, 32'h12,  32'h0,        1, 0, 0, 32'h0));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'hFFFFFFFF, 0, 1, 0, 32'h0));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'hFFFFFFFF, 1, 1, 0, 32'h0));
        vt.push_back(mk(1, NS, 0, 3, 32'h10,  32'h0,        1, 0, 0, 32'h0));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        0, 1, 1, 32'h11223355));
        vt.push_back(mk(1, NS, 0, 2, 32'h10,  32'h0,        1, 1, 1, 32'h11223355));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        1, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(1, BU, 0, 2, 32'h20,  32'h0,        1, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        1, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(0, NS, 0, 2, 32'h20,  32'h0,        1, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        1, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(1, NS, 0, 2, 32'h20,  32'h0,        1, 0, 1, 32'hDEADBEEF));
        vt.push_back(mk(1, SQ, 0, 2, 32'h30,  32'h0,        1, 0, 1, 32'h1234AB00));
        vt.push_back(mk(1, NS, 1, 2, 32'hFC,  32'h0,        1, 0, 1, 32'h11223355));
        vt.push_back(mk(1, NS, 0, 2, 32'hFC,  32'hCAFEF00D, 1, 0, 0, 32'h0));
        vt.push_back(mk(0, ID, 0, 0, 32'h0,   32'h0,        1, 0, 1, 32'hCAFEF00D));

        // Reset: both instances idle with cleared read data.
        srst  = 1'b1;
        hold0 = 1'b0;
        drive0(0, ID, 0, 0, 32'h0, 32'h0);
        i3.HSEL = 1'b0; i3.HTRANS = ID; i3.HWRITE = 1'b0; i3.HSIZE = 3'd0;
        i3.HADDR = 32'h0; i3.HWDATA = 32'h0; i3.HBURST = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst0.rdy",   32'(i0.HREADYOUT), 32'd1);
        check("rst0.resp",  32'(i0.HRESP),     32'd0);
        check("rst0.rdata", i0.HRDATA,         32'h0);
        check("rst3.rdy",   32'(i3.HREADYOUT), 32'd1);
        check("rst3.resp",  32'(i3.HRESP),     32'd0);
        check("rst3.rdata", i3.HRDATA,         32'h0);
        @(posedge clk); #1;
        srst = 1'b0;

        foreach (vt[i]) begin
            step0(vt[i].sel, vt[i].tr, vt[i].wr, vt[i].sz, vt[i].a, vt[i].wd);
            $display("vec %0d sel=%0d trans=%0d wr=%0d size=%0d addr=%h wdata=%h -> rdy=%0d resp=%0d rdata=%h",
                     i, vt[i].sel, vt[i].tr, vt[i].wr, vt[i].sz, vt[i].a, vt[i].wd,
                     i0.HREADYOUT, i0.HRESP, i0.HRDATA);
            check($sformatf("v%0d.rdy", i),  32'(i0.HREADYOUT), 32'(vt[i].rdy));
            check($sformatf("v%0d.resp", i), 32'(i0.HRESP),     32'(vt[i].resp));
            if (vt[i].chk) begin
                check($sformatf("v%0d.rdata", i), i0.HRDATA, vt[i].rd);
            end
        end

        // HREADY low from elsewhere holds an address phase unaccepted.
        step0(1, NS, 1, 2, 32'h40, 32'h0);
        step0(0, ID, 0, 0, 32'h0,  32'h01010101);
        @(posedge clk); #1;
        hold0 = 1'b1;
        drive0(1, NS, 1, 2, 32'h40, 32'h0);
        @(negedge clk);
        @(posedge clk); #1;
        hold0 = 1'b0;
        drive0(0, ID, 0, 0, 32'h0, 32'hFFFFFFFF);
        @(negedge clk);
        step0(1, NS, 0, 2, 32'h40, 32'h0);
        step0(0, ID, 0, 0, 32'h0,  32'h0);
        $display("hold test rdata=%h", i0.HRDATA);
        check("hold.rdata", i0.HRDATA, 32'h01010101);

        // Reset during a write data phase discards the write.
        step0(1, NS, 1, 2, 32'h40, 32'h0);
        @(posedge clk); #1;
        srst = 1'b1;
        drive0(0, ID, 0, 0, 32'h0, 32'hFFFFFFFF);
        @(negedge clk);
        @(posedge clk); #1;
        srst = 1'b0;
        drive0(0, ID, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        check("rstmid.rdy",   32'(i0.HREADYOUT), 32'd1);
        check("rstmid.resp",  32'(i0.HRESP),     32'd0);
        check("rstmid.rdata", i0.HRDATA,         32'h0);
        step0(1, NS, 0, 2, 32'h40, 32'h0);
        step0(0, ID, 0, 0, 32'h0,  32'h0);
        $display("mid-write reset readback rdata=%h", i0.HRDATA);
        check("rstmid.word", i0.HRDATA, 32'h01010101);

        // Three wait states.
        xfer3(1, 3'd2, 32'h04, 32'hA5A5A5A5, lows, resp, rd);
        check("ws3.wr.lows", 32'(lows), 32'd3);
        check("ws3.wr.resp", 32'(resp), 32'd0);
        xfer3(0, 3'd2, 32'h04, 32'h0, lows, resp, rd);
        check("ws3.rd.lows",  32'(lows), 32'd3);
        check("ws3.rd.resp",  32'(resp), 32'd0);
        check("ws3.rd.rdata", rd,        32'hA5A5A5A5);
        xfer3(1, 3'd0, 32'h07, 32'h3C000000, lows, resp, rd);
        check("ws3.wb.lows", 32'(lows), 32'd3);
        xfer3(0, 3'd2, 32'h04, 32'h0, lows, resp, rd);
        check("ws3.rb.rdata", rd, 32'h3CA5A5A5);
        xfer3(0, 3'd2, 32'h100, 32'h0, lows, resp, rd);
        check("ws3.err.lows",  32'(lows), 32'd1);
        check("ws3.err.resp",  32'(resp), 32'd1);
        check("ws3.err.rdata", rd,        32'h3CA5A5A5);

        // BUSY with HSEL is not a transfer: no wait states, OKAY.
        @(posedge clk); #1;
        i3.HSEL = 1'b1; i3.HTRANS = BU; i3.HADDR = 32'h04;
        @(negedge clk);
        @(posedge clk); #1;
        i3.HSEL = 1'b0; i3.HTRANS = ID;
        @(negedge clk);
        $display("ws3 busy -> rdy=%0d resp=%0d", i3.HREADYOUT, i3.HRESP);
        check("ws3.busy.rdy",  32'(i3.HREADYOUT), 32'd1);
        check("ws3.busy.resp", 32'(i3.HRESP),     32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
